// File: rtl/cr16_control.sv
// cr16_control -- multi-cycle CR16 subset control unit.
// Sequences FETCH -> DECODE -> EXECUTE -> WRITEBACK per instruction and
// drives the register-file / ALU / shifter controls plus the program counter.
// Optional feature macro: CR16_BRANCH_EN enables Bcond (op 1100). When the
// macro is undefined, op 1100 is a NOP and the pc only ever increments.
module cr16_control (
   input  logic        clk,
   input  logic        reset,
   output logic        memRead,
   output logic [15:0] memAddr,
   input  logic [15:0] memData,
   input  logic        memValid,
   output logic [15:0] pc,
   output logic [15:0] srcAddr,
   output logic [15:0] dstAddr,
   output logic [15:0] immd,
   output logic        pcInstruction,
   output logic        rTypeInstruction,
   output logic        shiftInstruction,
   output logic        regWrite,
   output logic [2:0]  aluOp,
   output logic [3:0]  shiftAmount,
   input  logic [15:0] resultData,
   input  logic [15:0] outputFlags,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_CMP = 3'b101;
   localparam logic [2:0] ALU_MOV = 3'b110;

   state_t      state;
   state_t      state_next;
   logic [15:0] ir;

   // decoded fields (combinational, from ir)
   logic [3:0]  op;
   logic [3:0]  rd;
   logic [3:0]  ext;
   logic [3:0]  rs;
   logic [15:0] imm_sext;
   logic [15:0] imm_zext;

   logic [2:0]  d_alu;
   logic [15:0] d_immd;
   logic        d_rtype;
   logic        d_shift;
   logic        d_pcinstr;
   logic        d_write;
   logic        d_branch;

   // decode results held from DECODE through WRITEBACK
   logic        write_q;
   logic        branch_q;
   logic [3:0]  cond_q;
   logic        taken;

   // flag bits other than zero/negative are not consumed by this unit
   logic        unused_flags;

   assign op       = ir[15:12];
   assign rd       = ir[11:8];
   assign ext      = ir[7:4];
   assign rs       = ir[3:0];
   assign imm_sext = {{8{ir[7]}}, ir[7:0]};
   assign imm_zext = {8'd0, ir[7:0]};
   assign memAddr  = pc;
   assign unused_flags = ^{outputFlags[15:5], outputFlags[2:0]};

   function automatic logic cond_taken(input logic [3:0] c, input logic z, input logic n);
      case (c)
         4'b0000: return z;            // EQ
         4'b0001: return !z;           // NE
         4'b0110: return !n && !z;     // GT
         4'b1110: return 1'b1;         // always
         default: return 1'b0;         // never
      endcase
   endfunction

   assign taken = branch_q && cond_taken(cond_q, outputFlags[3], outputFlags[4]);

   // Instruction decode; anything not recognised falls through as a NOP.
   always_comb begin
      d_alu     = ALU_ADD;
      d_immd    = 16'd0;
      d_rtype   = 1'b0;
      d_shift   = 1'b0;
      d_pcinstr = 1'b0;
      d_write   = 1'b0;
      d_branch  = 1'b0;
      case (op)
         4'b0000: begin
            case (ext)
               4'b0101: begin d_alu = ALU_ADD; d_rtype = 1'b1; d_write = 1'b1; end
               4'b1001: begin d_alu = ALU_SUB; d_rtype = 1'b1; d_write = 1'b1; end
               4'b0001: begin d_alu = ALU_AND; d_rtype = 1'b1; d_write = 1'b1; end
               4'b0010: begin d_alu = ALU_OR;  d_rtype = 1'b1; d_write = 1'b1; end
               4'b0011: begin d_alu = ALU_XOR; d_rtype = 1'b1; d_write = 1'b1; end
               4'b1011: begin d_alu = ALU_CMP; d_rtype = 1'b1; end
               4'b1101: begin d_alu = ALU_MOV; d_rtype = 1'b1; d_write = 1'b1; end
               default: ;
            endcase
         end
         4'b0101: begin d_alu = ALU_ADD; d_immd = imm_sext; d_write = 1'b1; end
         4'b1001: begin d_alu = ALU_SUB; d_immd = imm_sext; d_write = 1'b1; end
         4'b0001: begin d_alu = ALU_AND; d_immd = imm_zext; d_write = 1'b1; end
         4'b0010: begin d_alu = ALU_OR;  d_immd = imm_zext; d_write = 1'b1; end
         4'b0011: begin d_alu = ALU_XOR; d_immd = imm_zext; d_write = 1'b1; end
         4'b1011: begin d_alu = ALU_CMP; d_immd = imm_sext; end
         4'b1101: begin d_alu = ALU_MOV; d_immd = imm_sext; d_write = 1'b1; end
         4'b1000: begin
            if (ext == 4'b0000) begin
               d_shift = 1'b1;
               d_write = 1'b1;
            end
         end
`ifdef CR16_BRANCH_EN
         4'b1100: begin
            d_pcinstr = 1'b1;
            d_alu     = ALU_ADD;
            d_immd    = imm_sext;
            d_branch  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   // Next-state logic; HALT is only left through reset.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:     if (memValid) state_next = S_DECODE;
         S_DECODE:    state_next = (op == 4'b1111) ? S_HALT : S_EXECUTE;
         S_EXECUTE:   state_next = S_WRITEBACK;
         S_WRITEBACK: state_next = S_FETCH;
         S_HALT:      state_next = S_HALT;
         default:     state_next = S_FETCH;
      endcase
   end

   // State-decoded outputs; regWrite is masked by reset so a reset landing
   // in WRITEBACK never commits the write.
   always_comb begin
      memRead  = (state == S_FETCH);
      halted   = (state == S_HALT);
      regWrite = (state == S_WRITEBACK) && write_q && !reset;
   end

   // Instruction register, registered decode outputs and program counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir               <= 16'd0;
         pc               <= 16'd0;
         srcAddr          <= 16'd0;
         dstAddr          <= 16'd0;
         immd             <= 16'd0;
         aluOp            <= 3'd0;
         shiftAmount      <= 4'd0;
         pcInstruction    <= 1'b0;
         rTypeInstruction <= 1'b0;
         shiftInstruction <= 1'b0;
         write_q          <= 1'b0;
         branch_q         <= 1'b0;
         cond_q           <= 4'd0;
      end else begin
         case (state)
            S_FETCH: begin
               if (memValid) ir <= memData;
            end
            S_DECODE: begin
               srcAddr          <= {12'd0, rs};
               dstAddr          <= {12'd0, rd};
               immd             <= d_immd;
               aluOp            <= d_alu;
               shiftAmount      <= d_shift ? rs : 4'd0;
               pcInstruction    <= d_pcinstr;
               rTypeInstruction <= d_rtype;
               shiftInstruction <= d_shift;
               write_q          <= d_write;
               branch_q         <= d_branch;
               cond_q           <= rd;
            end
            S_WRITEBACK: begin
               pc <= taken ? resultData : pc + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cr16_control.sv
// Directed testbench for cr16_control. Builds with or without CR16_BRANCH_EN.
module tb_cr16_control;

   logic        clk = 1'b0;
   logic        reset;
   logic        memRead;
   logic [15:0] memAddr;
   logic [15:0] memData;
   logic        memValid;
   logic [15:0] pc, srcAddr, dstAddr, immd;
   logic        pcInstruction, rTypeInstruction, shiftInstruction, regWrite;
   logic [2:0]  aluOp;
   logic [3:0]  shiftAmount;
   logic [15:0] resultData;
   logic [15:0] outputFlags;
   logic        halted;

   int checks = 0;
   int errors = 0;

   // values captured by exec()
   int          rw_count, rw_cycle, mr_count;
   logic [15:0] cap_dst, cap_src, cap_immd;
   logic [2:0]  cap_alu;
   logic [3:0]  cap_shamt;
   logic        cap_rtype, cap_shift, cap_pcinstr;

   cr16_control dut (
      .clk(clk), .reset(reset),
      .memRead(memRead), .memAddr(memAddr), .memData(memData), .memValid(memValid),
      .pc(pc), .srcAddr(srcAddr), .dstAddr(dstAddr), .immd(immd),
      .pcInstruction(pcInstruction), .rTypeInstruction(rTypeInstruction),
      .shiftInstruction(shiftInstruction), .regWrite(regWrite),
      .aluOp(aluOp), .shiftAmount(shiftAmount),
      .resultData(resultData), .outputFlags(outputFlags), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One instruction: waits cycles of memValid=0, then memValid=1, then the
   // remaining three cycles. Ends at the start of the next FETCH cycle.
   task automatic exec(input logic [15:0] instr, input int waits);
      rw_count = 0; rw_cycle = 0; mr_count = 0;
      for (int c = 1; c <= waits + 4; c++) begin
         memData  = instr;
         memValid = (c == waits + 1);
         #1;
         if (memRead) mr_count++;
         if (regWrite) begin rw_count++; rw_cycle = c; end
         if (c == waits + 4) begin
            cap_dst = dstAddr; cap_src = srcAddr; cap_immd = immd; cap_alu = aluOp;
            cap_shamt = shiftAmount; cap_rtype = rTypeInstruction;
            cap_shift = shiftInstruction; cap_pcinstr = pcInstruction;
         end
         tick();
      end
      memValid = 1'b0;
   endtask

   initial begin
      int bad;
      reset = 1'b1; memData = 16'd0; memValid = 1'b0;
      resultData = 16'd0; outputFlags = 16'd0;
      tick();
      tick();
      check("rst_regwrite_in_reset", regWrite, 0);
      reset = 1'b0;
      #1;
      check("rst_pc", pc, 16'h0000);
      check("rst_memaddr", memAddr, 16'h0000);
      check("rst_immd", immd, 16'h0000);
      check("rst_aluop", aluOp, 3'd0);
      check("rst_ctrl", {pcInstruction, rTypeInstruction, shiftInstruction, shiftAmount}, 0);
      check("rst_addrs", {srcAddr, dstAddr}, 0);
      check("rst_halted", halted, 0);
      check("rst_memread_fetch", memRead, 1);
      check("rst_regwrite_after", regWrite, 0);

      // ADDI r3,#5
      exec(16'h5305, 0);
      check("addi_rw_count", rw_count, 1);
      check("addi_rw_cycle", rw_cycle, 4);
      check("addi_dst", cap_dst, 16'h0003);
      check("addi_immd", cap_immd, 16'h0005);
      check("addi_rtype", cap_rtype, 0);
      check("addi_pc", pc, 16'h0001);
      check("addi_memread", mr_count, 1);

      // ADD r1,r2 with memValid delayed 3 cycles
      exec(16'h0152, 3);
      check("add_memread_cycles", mr_count, 4);
      check("add_rw_count", rw_count, 1);
      check("add_rw_cycle", rw_cycle, 7);
      check("add_aluop", cap_alu, 3'b000);
      check("add_rtype", cap_rtype, 1);
      check("add_src_dst", {cap_src, cap_dst}, {16'h0002, 16'h0001});
      check("add_pc", pc, 16'h0002);

      // LSHI r2, right 1
      exec(16'h8209, 0);
      check("lshi_shift", cap_shift, 1);
      check("lshi_shamt", cap_shamt, 4'h9);
      check("lshi_rw", rw_count, 1);
      check("lshi_dst", cap_dst, 16'h0002);

      // CMPI r1,#-1
      exec(16'hB1FF, 0);
      check("cmpi_rw", rw_count, 0);
      check("cmpi_immd", cap_immd, 16'hFFFF);
      check("cmpi_aluop", cap_alu, 3'b101);

      // ANDI zero-extends, SUBI sign-extends
      exec(16'h1280, 0);
      check("andi_immd", cap_immd, 16'h0080);
      check("andi_aluop", cap_alu, 3'b010);
      check("andi_rw", rw_count, 1);
      exec(16'h9480, 0);
      check("subi_immd", cap_immd, 16'hFF80);
      check("subi_aluop", cap_alu, 3'b001);

      // R-type with undefined ext, and undefined opcode: NOPs
      exec(16'h0170, 0);
      check("rnop_rw", rw_count, 0);
      exec(16'h4000, 0);
      check("opnop_rw", rw_count, 0);
      check("nop_pc", pc, 16'h0008);

      // MOV r3,r4 register form
      exec(16'h03D4, 0);
      check("mov_aluop", cap_alu, 3'b110);
      check("mov_rtype", cap_rtype, 1);
      check("mov_rw", rw_count, 1);
      exec(16'h4000, 0);
      check("pc_before_beq", pc, 16'd10);

      // BEQ -4 with zero set, resultData = 6
      outputFlags = 16'h0008; resultData = 16'd6;
      exec(16'hC0FC, 0);
      check("beq_rw", rw_count, 0);
`ifdef CR16_BRANCH_EN
      check("beq_taken_pc", pc, 16'd6);
      check("beq_pcinstr", cap_pcinstr, 1);
      check("beq_immd", cap_immd, 16'hFFFC);
      check("beq_aluop", cap_alu, 3'b000);
      outputFlags = 16'h0000;
      for (int i = 0; i < 4; i++) exec(16'h4000, 0);
      check("pc_back_10", pc, 16'd10);
      exec(16'hC0FC, 0);
      check("beq_not_taken_pc", pc, 16'd11);
      check("beq2_rw", rw_count, 0);
      // GT with negative set is not taken
      outputFlags = 16'h0010; resultData = 16'h0077;
      exec(16'hC605, 0);
      check("bgt_neg_pc", pc, 16'd12);
      // always-taken branch to FFFF, then a NOP wraps pc
      outputFlags = 16'h0000; resultData = 16'hFFFF;
      exec(16'hCE05, 0);
      check("bal_pc", pc, 16'hFFFF);
      exec(16'h4000, 0);
      check("pc_wrap", pc, 16'h0000);
`else
      check("beq_disabled_pc", pc, 16'd11);
      check("beq_disabled_pcinstr", cap_pcinstr, 0);
      outputFlags = 16'h0000;
      exec(16'hC0FC, 0);
      check("beq_disabled_pc2", pc, 16'd12);
`endif

      // HALT
      memData = 16'hF000; memValid = 1'b1;
      tick();
      memValid = 1'b0;
      tick();
      check("halt_halted", halted, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         memValid = 1'b1;
         #1;
         if (memRead || regWrite || !halted) bad++;
         tick();
      end
      memValid = 1'b0;
      check("halt_quiet_20", bad, 0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("halt_cleared", halted, 0);
      check("halt_reset_pc", pc, 16'h0000);

      // reset landing in WRITEBACK of an ADD
      memData = 16'h0152; memValid = 1'b1;
      tick();
      memValid = 1'b0;
      tick();
      tick();
      check("wb_regwrite_before_reset", regWrite, 1);
      reset = 1'b1;
      #1;
      check("wb_regwrite_masked", regWrite, 0);
      tick();
      check("wb_reset_regwrite_2", regWrite, 0);
      reset = 1'b0;
      #1;
      check("wb_reset_pc", pc, 16'h0000);
      check("wb_reset_fetch", memRead, 1);
      check("wb_reset_ctrl", {rTypeInstruction, dstAddr, srcAddr, aluOp}, 0);
      check("wb_reset_regwrite_after", regWrite, 0);
      tick();
      check("wb_reset_still_fetch", memRead, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
